dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the CPU load/store port and the slow word-organised data memory.
- Holds 8 lines of 4 bytes each with tag/valid/dirty state.
- Stalls the CPU with `busywait` while it evicts dirty blocks and refills from memory.

## Interface
Parameters:
- `LINES`, 8: number of cache lines; fixes the index width at 3.
- `TAG_W`, 3: tag width; address split is {tag[7:5], index[4:2], offset[1:0]}.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `read` in 1: CPU load request.
- `write` in 1: CPU store request.
- `address` in 8: CPU byte address.
- `writedata` in 8: CPU store byte.
- `readdata` out 8: CPU load byte.
- `busywait` out 1: CPU stall; request inputs must be held stable while it is high.
- `mem_read` out 1: memory block read strobe.
- `mem_write` out 1: memory block write strobe.
- `mem_address` out 6: block address {tag, index}.
- `mem_writedata` out 32: evicted block; byte 0 is in [7:0].
- `mem_readdata` in 32: fetched block.
- `mem_busywait` in 1: memory busy; the transfer completes at the first rising edge where it is low while a strobe is high.

## Operation
- Per-line storage: 32-bit data, 3-bit tag, valid bit, dirty bit. `hit` = valid[index] && tag[index]==address tag.
- FSM states:
  - IDLE:
    - Hit: served here.
    - Miss with dirty line → WRITEBACK.
    - Miss with clean or invalid line → FETCH.
  - WRITEBACK:
    - Drives `mem_write`=1, `mem_address`={stored tag, index}, `mem_writedata`=line data.
    - On completion → FETCH.
  - FETCH:
    - Drives `mem_read`=1, `mem_address`={request tag, index}.
    - On completion, latches `mem_readdata` → UPDATE.
  - UPDATE:
    - Writes the block into the line, sets tag, valid=1, dirty=0.
    - → IDLE, where the request then hits.
- Read hit: `readdata` = byte `offset` of the line, combinational from `address`.
- Write hit: the byte at `offset` is written and dirty is set at the rising edge.
- `read` and `write` both high: treated as a write. `readdata` is don't-care.
- Neither asserted: no state change, `busywait`=0.
- Memory strobes are mutually exclusive and driven only in WRITEBACK/FETCH.

## Timing
- Reset (async, `rst_n`=0):
  - State→IDLE; all valid and dirty bits cleared.
  - `busywait`, `mem_read`, `mem_write` = 0; `mem_address`=0, `mem_writedata`=0, `readdata`=0.
  - Data and tag arrays are not cleared.
- Reset asserted mid-WRITEBACK or mid-FETCH aborts immediately. The strobes fall in the same instant, not at the next edge.
- `busywait` = (read|write) && !(state==IDLE && hit). Combinational, so it is high in the same cycle a miss is presented.
- Hit latency: 0 stall cycles. A write commits at the edge closing the request cycle.
- Clean-miss penalty: 1 IDLE cycle + FETCH cycles (≥1) + 1 UPDATE cycle. The hit completes in the following IDLE cycle.
- Dirty miss: adds the WRITEBACK cycles (≥1) before FETCH.
- A strobe is held constant across all memory-busy cycles. No re-issue and no gap cycle between WRITEBACK and FETCH.
- Same-index different-tag back-to-back requests: each incurs its own miss. A line is never read and refilled in the same cycle.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds output ports `hit_count` (16) and `miss_count` (16), both reset to 0.
  - `hit_count` increments on each IDLE cycle with a request and a hit, which includes the post-refill completion.
  - `miss_count` increments on each IDLE→WRITEBACK or IDLE→FETCH transition.
  - Both counters saturate at 16'hFFFF.
- `DCACHE_STATS_EN` undefined: ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset then read `address`=8'h24, memory busy 3 cycles, block 32'hDDCCBBAA:
  - `busywait`=1 from request through UPDATE.
  - `readdata`=8'hAA once `busywait` falls.
  - Exactly one `mem_read` burst with `mem_address`=6'h09.
- Write 8'h5A to 8'h25 after that fill:
  - No stall.
  - A subsequent read of 8'h25 returns 8'h5A with `busywait`=0.
- Read 8'hA4 (same index, tag 5):
  - WRITEBACK first: `mem_write`=1, `mem_address`=6'h09, `mem_writedata`=32'hDDCC5AAA.
  - Then FETCH at `mem_address`=6'h29.
- Read and write both high on a hit: the write is applied and the dirty bit is observed via a later eviction.
- `rst_n` pulsed low mid-FETCH: strobes drop asynchronously, and a re-issued read of the same address misses again.
- With `DCACHE_STATS_EN`, run the scenarios above in order: `hit_count`=4, `miss_count`=2.

Source files
------------

// File: rtl/dcache_if.sv
// CPU load/store port plus word-organised memory port of the data cache controller.
interface dcache_if;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    // Cache controller side: serves the CPU, masters the memory.
    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    // Environment side: CPU requester and memory responder.
    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller (8 lines x 4 bytes).
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int unsigned LINES = 8,
    parameter int unsigned TAG_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned OFF_W = 2;
    localparam int unsigned BLK_W = 32;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t             state_q, state_d;
    logic [BLK_W-1:0]   data_q [LINES];
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [BLK_W-1:0]   fill_q;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [OFF_W-1:0]   off;
    logic               hit;
    logic               req;
    logic               wr_hit;

    assign idx    = bus.address[OFF_W +: IDX_W];
    assign tag    = bus.address[OFF_W+IDX_W +: TAG_W];
    assign off    = bus.address[OFF_W-1:0];
    assign hit    = valid_q[idx] && (tag_q[idx] == tag);
    assign req    = bus.read || bus.write;
    assign wr_hit = (state_q == IDLE) && bus.write && hit;

    // Stall and load data are combinational so hits complete with zero wait.
    assign bus.busywait = rst_n && req && !((state_q == IDLE) && hit);
    assign bus.readdata = hit ? data_q[idx][{off, 3'b000} +: 8] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory strobes; strobes decode from state so reset drops them at once.
    always_comb begin
        state_d           = state_q;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = 6'h00;
        bus.mem_writedata = 32'h0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = dirty_q[idx] ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                bus.mem_write     = 1'b1;
                bus.mem_address   = {tag_q[idx], idx};
                bus.mem_writedata = data_q[idx];
                if (!bus.mem_busywait) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = {tag, idx};
                if (!bus.mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Data/tag arrays and the fill buffer are intentionally left unreset.
    always_ff @(posedge clk) begin
        if ((state_q == FETCH) && !bus.mem_busywait) begin
            fill_q <= bus.mem_readdata;
        end
        if (state_q == UPDATE) begin
            data_q[idx] <= fill_q;
            tag_q[idx]  <= tag;
        end else if (wr_hit) begin
            data_q[idx][{off, 3'b000} +: 8] <= bus.writedata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state_q == UPDATE) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // Saturating counters: hits per serving IDLE cycle, misses per IDLE exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else if ((state_q == IDLE) && req) begin
            if (hit && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (!hit && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: CPU loads and memory bursts are checked by monitors.
module tb_dcache_ctrl;

    logic clk;
    logic rst_n;
    dcache_if bus();

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    dcache_ctrl #(.LINES(8), .TAG_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        int          kind;   // 1 = block read, 2 = block write
        logic [5:0]  addr;
        logic [31:0] data;
    } burst_t;

    int          errors = 0;
    int          checks = 0;
    int          mem_lat = 0;
    int          wait_cnt = 0;
    int          prev_kind = 0;
    logic [31:0] mem_blk [64];
    logic [7:0]  rd_q [$];
    burst_t      burst_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory responder: holds mem_busywait for mem_lat cycles per strobe, then completes.
    initial begin
        bus.mem_busywait = 1'b0;
        bus.mem_readdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_read || bus.mem_write) begin
                if (wait_cnt < mem_lat) begin
                    bus.mem_busywait = 1'b1;
                    wait_cnt++;
                end else begin
                    bus.mem_busywait = 1'b0;
                    wait_cnt = 0;
                    if (bus.mem_write) mem_blk[bus.mem_address] = bus.mem_writedata;
                    else               bus.mem_readdata = mem_blk[bus.mem_address];
                end
            end else begin
                bus.mem_busywait = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: completed CPU loads.
    always @(negedge clk) begin
        if (rst_n && bus.read && !bus.write && !bus.busywait) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: readdata %h with no expected load", bus.readdata);
            end else begin
                chk("readdata", 32'(bus.readdata), 32'(rd_q.pop_front()));
            end
        end
    end

    // Monitor: memory bursts, one check set at the start of each strobe burst.
    always @(negedge clk) begin
        int kind;
        burst_t e;
        kind = bus.mem_write ? 2 : (bus.mem_read ? 1 : 0);
        if (kind != 0 && kind != prev_kind) begin
            chk("strobe_excl", 32'(bus.mem_read && bus.mem_write), 32'd0);
            if (burst_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_burst: kind %0d addr %h", kind, bus.mem_address);
            end else begin
                e = burst_q.pop_front();
                chk("burst_kind", 32'(kind), 32'(e.kind));
                chk("burst_addr", 32'(bus.mem_address), 32'(e.addr));
                if (e.kind == 2) chk("burst_wdata", bus.mem_writedata, e.data);
            end
        end
        prev_kind = kind;
    end

    task automatic cpu_op(input logic r, input logic w, input logic [7:0] a,
                          input logic [7:0] d, output int stalls);
        @(posedge clk);
        #1;
        bus.read = r; bus.write = w; bus.address = a; bus.writedata = d;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!bus.busywait) break;
            stalls++;
            if (stalls > 200) begin
                checks++;
                errors++;
                $display("FAIL stall_timeout: addr %h still busy after %0d cycles", a, stalls);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.read = 1'b0; bus.write = 1'b0;
    endtask

    task automatic push_burst(input int kind, input logic [5:0] addr, input logic [31:0] data);
        burst_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        burst_q.push_back(e);
    endtask

    initial begin
        int st;
        int n;
        for (int i = 0; i < 64; i++) mem_blk[i] = {8'(i), 8'(i), 8'(i), 8'(i)};
        mem_blk[6'h09] = 32'hDDCCBBAA;
        mem_blk[6'h29] = 32'h44332211;
        mem_blk[6'h11] = 32'hCAFEF00D;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = 8'h00; bus.writedata = 8'h00;
        rst_n = 1'b0;
        #12;
        chk("rst_busywait", 32'(bus.busywait), 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst_mem_writedata", bus.mem_writedata, 32'd0);
        chk("rst_readdata", 32'(bus.readdata), 32'd0);
`ifdef DCACHE_STATS_EN
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Clean miss: 1 IDLE + 4 FETCH + 1 UPDATE stall cycles.
        mem_lat = 3;
        push_burst(1, 6'h09, 32'h0);
        rd_q.push_back(8'hAA);
        cpu_op(1'b1, 1'b0, 8'h24, 8'h00, st);
        chk("stall_clean_miss", 32'(st), 32'd6);

        cpu_op(1'b0, 1'b1, 8'h25, 8'h5A, st);
        chk("stall_write_hit", 32'(st), 32'd0);
        rd_q.push_back(8'h5A);
        cpu_op(1'b1, 1'b0, 8'h25, 8'h00, st);
        chk("stall_read_hit", 32'(st), 32'd0);

        // Dirty miss: 1 IDLE + 3 WRITEBACK + 3 FETCH + 1 UPDATE.
        mem_lat = 2;
        push_burst(2, 6'h09, 32'hDDCC5AAA);
        push_burst(1, 6'h29, 32'h0);
        rd_q.push_back(8'h11);
        cpu_op(1'b1, 1'b0, 8'hA4, 8'h00, st);
        chk("stall_dirty_miss", 32'(st), 32'd8);
`ifdef DCACHE_STATS_EN
        chk("hit_count", 32'(hit_count), 32'd4);
        chk("miss_count", 32'(miss_count), 32'd2);
`endif

        // Read+write on a hit acts as a write; eviction then shows the new byte.
        cpu_op(1'b1, 1'b1, 8'hA6, 8'h77, st);
        chk("stall_rw_hit", 32'(st), 32'd0);
        mem_lat = 1;
        push_burst(2, 6'h29, 32'h44772211);
        push_burst(1, 6'h09, 32'h0);
        rd_q.push_back(8'h5A);
        cpu_op(1'b1, 1'b0, 8'h25, 8'h00, st);
        chk("stall_rw_evict", 32'(st), 32'd6);

        // Reset pulsed during FETCH aborts the transfer immediately.
        mem_lat = 5;
        push_burst(1, 6'h11, 32'h0);
        @(posedge clk);
        #1;
        bus.read = 1'b1; bus.address = 8'h44;
        n = 0;
        while (!bus.mem_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_started", 32'(bus.mem_read), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_read", 32'(bus.mem_read), 32'd0);
        chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
        chk("abort_busywait", 32'(bus.busywait), 32'd0);
        chk("abort_mem_address", 32'(bus.mem_address), 32'd0);
        bus.read = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        mem_lat = 5;
        push_burst(1, 6'h11, 32'h0);
        rd_q.push_back(8'h0D);
        cpu_op(1'b1, 1'b0, 8'h44, 8'h00, st);
        chk("stall_after_abort", 32'(st), 32'd8);
        rd_q.push_back(8'hCA);
        cpu_op(1'b1, 1'b0, 8'h47, 8'h00, st);
        chk("stall_offset3_hit", 32'(st), 32'd0);

        repeat (3) @(posedge clk);
        chk("loads_pending", 32'(rd_q.size()), 32'd0);
        chk("bursts_pending", 32'(burst_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
